counter_limit_monitor: RTL
==========================

Name: counter_limit_monitor

Overview:
- Downstream consumer of the 8-bit enable-driven up-counter's output; watches the live count every clock.
- Produces a registered over-limit flag, a sticky alarm with software clear, a saturating violation counter, a peak tracker and a wrap/discontinuity pulse.
- Sits beside the counter in the subsystem; its outputs feed status registers and the interrupt aggregator.

Parameters:
- WIDTH, 8, width of the observed counter and of peak.
- LIMIT, 100, maximum legal count; any value > LIMIT is a violation.
- VIOL_CNT_W, 8, width of the saturating violation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  the same enable that drives the counter.
- counter  input  WIDTH  live counter value.
- clr_alarm  input  1  single-cycle pulse; clears alarm (and step_err when compiled in).
- over_limit  output  1  registered, (counter > LIMIT) delayed one cycle.
- alarm  output  1  sticky violation flag.
- viol_count  output  VIOL_CNT_W  number of violation entries, saturating.
- peak  output  WIDTH  largest counter value sampled while monitoring.
- wrap_seen  output  1  one-cycle pulse when the count decreased.
- mon_state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 ALARM.
- step_err  output  1  sticky step-check error (optional feature).

Behaviour:
- Reset (async, reset_n=0):
  - all outputs go to 0 immediately; state goes to IDLE.
  - internal cnt_q, en_q and valid_q go to 0.
  - Release is synchronous to the next clk edge. Reset asserted mid-alarm discards all history.
- Sampling: every edge, cnt_q<=counter and en_q<=enable.
  - valid_q<=1 on the first edge in ARMED or ALARM, and stays 1 until reset.
- over_limit: registered from (counter > LIMIT) every cycle in any state, 1-cycle latency. Comparison is unsigned. counter==LIMIT is legal.
- FSM:
  - IDLE -> ARMED when enable=1 at a clock edge. No violation, peak or wrap logic runs in IDLE.
  - ARMED -> ALARM when counter > LIMIT at the edge. alarm asserts on that same edge, in the same cycle as over_limit.
  - ALARM -> ARMED on clr_alarm=1 with counter <= LIMIT. alarm deasserts on that edge.
  - clr_alarm=1 with counter > LIMIT: stays ALARM and alarm stays 1; a clear never hides a live violation.
  - clr_alarm in IDLE or ARMED: no effect on state.
  - There is no return to IDLE except reset.
- viol_count:
  - +1 on each entry into violation, i.e. (counter > LIMIT) && !over_limit, in ARMED or ALARM.
  - Holds at 2^VIOL_CNT_W-1. Not cleared by clr_alarm; only reset clears it.
  - Same-cycle clr_alarm and new entry: the violation wins, alarm stays 1, and the count increments.
- peak: in ARMED or ALARM, peak<=counter when counter > peak. Updates use the current-cycle value, so peak has 1-cycle latency.
- wrap_seen: 1-cycle pulse when valid_q && counter < cnt_q. This covers a natural 255->0 wrap and a forced lower write.

Optional Feature:
- Macro: COUNTER_MON_STEP_CHK_EN.
- Defined: in ARMED or ALARM with valid_q=1, the bench/RTL expects counter == cnt_q+1 (mod 2^WIDTH) when en_q=1, and counter == cnt_q when en_q=0.
  - A mismatch sets step_err (sticky) on that edge.
  - clr_alarm clears step_err unless a mismatch occurs in the same cycle; the mismatch wins.
- Not defined: the step-check logic is absent and step_err is tied to 0.

Test Plan:
- Reset then enable=1 at cycle 2, counter ramps 0..50 -> mon_state 0->1 one edge after enable, alarm=0, over_limit=0, peak=50, viol_count=0.
- Counter ramps to 100 then 101 -> over_limit and alarm assert on the edge sampling 101, mon_state=2, viol_count=1. At 100 only, both stay 0.
- In ALARM, pulse clr_alarm while counter=120 -> alarm stays 1. Force counter=40, pulse clr_alarm -> alarm=0, mon_state=1, viol_count unchanged; wrap_seen pulses once on the 120->40 drop.
- Clear and re-violation in the same cycle (counter 100->101 with clr_alarm=1) -> alarm=1, viol_count increments by 1. Driving 300 separate entries -> viol_count saturates at 255.
- Assert reset_n=0 mid-clock while alarm=1 and peak=120 -> all outputs 0 without waiting for clk, and mon_state=IDLE.
- With COUNTER_MON_STEP_CHK_EN: enable=1 and counter jumps 10->12 -> step_err=1 next edge. Without the macro, the same stimulus gives step_err=0.

Source files
------------

// File: rtl/counter_limit_monitor.sv
// counter_limit_monitor
//
// Watches the live value of the 8-bit enable-driven up-counter and reports
// limit violations to the status registers and the interrupt aggregator.
//
// Optional feature macro: COUNTER_MON_STEP_CHK_EN
//   When defined, every monitored cycle checks that the counter moved exactly
//   as its enable dictated. A mismatch sets the sticky step_err flag.
//   When undefined, the step checker is absent and step_err is tied to 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   enable      the same enable that drives the counter
//   counter     live counter value
//   clr_alarm   single-cycle pulse, clears alarm (and step_err when built in)
//   over_limit  registered (counter > LIMIT), one cycle of latency
//   alarm       sticky violation flag
//   viol_count  saturating count of entries into violation
//   peak        largest counter value seen while monitoring
//   wrap_seen   one-cycle pulse when the count went down
//   mon_state   FSM state: 0 IDLE, 1 ARMED, 2 ALARM
//   step_err    sticky step-check error

module counter_limit_monitor #(
    parameter int WIDTH      = 8,
    parameter int LIMIT      = 100,
    parameter int VIOL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      counter,
    input  logic                  clr_alarm,
    output logic                  over_limit,
    output logic                  alarm,
    output logic [VIOL_CNT_W-1:0] viol_count,
    output logic [WIDTH-1:0]      peak,
    output logic                  wrap_seen,
    output logic [1:0]            mon_state,
    output logic                  step_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]      LIMIT_V  = WIDTH'(LIMIT);
    localparam logic [VIOL_CNT_W-1:0] VIOL_MAX = '1;

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] cnt_q;
    logic            valid_q;
    logic            live_viol;
    logic            viol_entry;
    logic            monitoring;

    // A violation "entry" is the first cycle above the limit; over_limit still
    // holds last cycle's comparison, so it tells us whether we were already
    // above it.
    assign live_viol  = (counter > LIMIT_V);
    assign viol_entry = live_viol && !over_limit;
    assign monitoring = (state != IDLE);

    // The alarm flag is simply the ALARM state, so it can never disagree with
    // mon_state and it clears with the same edge that leaves ALARM.
    assign alarm     = (state == ALARM);
    assign mon_state = state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Once armed, the monitor never returns to IDLE; only
    // reset does that. A clear is ignored while the count is still above the
    // limit so a live violation can never be hidden.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (live_viol) begin
                    next_state = ALARM;
                end
            end
            ALARM: begin
                if (clr_alarm && !live_viol) begin
                    next_state = ARMED;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sampling and monitoring datapath. over_limit runs in every state; the
    // violation counter, peak tracker and wrap detector only run once armed.
    // valid_q marks that cnt_q holds a value captured while monitoring, so the
    // wrap detector never compares against a stale pre-arm sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            over_limit <= 1'b0;
            viol_count <= '0;
            peak       <= '0;
            wrap_seen  <= 1'b0;
        end else begin
            cnt_q      <= counter;
            over_limit <= live_viol;
            wrap_seen  <= valid_q && (counter < cnt_q);
            if (monitoring) begin
                valid_q <= 1'b1;
                if (viol_entry && (viol_count != VIOL_MAX)) begin
                    viol_count <= viol_count + VIOL_CNT_W'(1);
                end
                if (counter > peak) begin
                    peak <= counter;
                end
            end
        end
    end

`ifdef COUNTER_MON_STEP_CHK_EN
    logic             en_q;
    logic             step_err_q;
    logic [WIDTH-1:0] expected_cnt;
    logic             step_mismatch;

    // The counter should advance by exactly one (wrapping) when it was enabled
    // last cycle and hold otherwise.
    assign expected_cnt  = en_q ? (cnt_q + WIDTH'(1)) : cnt_q;
    assign step_mismatch = monitoring && valid_q && (counter != expected_cnt);
    assign step_err      = step_err_q;

    // Sticky step error; a mismatch in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            en_q <= enable;
            if (step_mismatch) begin
                step_err_q <= 1'b1;
            end else if (clr_alarm) begin
                step_err_q <= 1'b0;
            end
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule
